// File: rtl/lz_denorm_pkg.sv
// lz_denorm_pkg: shared defaults and state encoding for the leading-zero denormalizer.
package lz_denorm_pkg;
   localparam int DEF_DATA_W = 279;
   localparam int DEF_OUT_W  = 9;
   localparam int DEF_MANT_W = 24;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/lz_denorm_shift_stage.sv
// lz_denorm_shift_stage: one conditional right shift by a power of two, reporting any bits dropped.
module lz_denorm_shift_stage
   import lz_denorm_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int OUT_W  = DEF_OUT_W
) (
   input  logic [DATA_W-1:0] work,
   input  logic [OUT_W-1:0]  amount,
   input  logic              enable,
   output logic [DATA_W-1:0] work_nxt,
   output logic              dropped_or
);
   // Amounts at or beyond DATA_W yield an all-ones mask and a cleared word.
   assign work_nxt   = enable ? work >> amount : work;
   assign dropped_or = enable & |(work & ~({DATA_W{1'b1}} << amount));
endmodule

// File: rtl/lz_denorm.sv
// lz_denorm: rebuilds a wide fixed-point word from a left-aligned mantissa and a leading-zero count,
// applying one count bit per cycle through a single reused shift stage.
module lz_denorm
   import lz_denorm_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int OUT_W  = DEF_OUT_W,
   parameter int MANT_W = DEF_MANT_W
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [MANT_W-1:0] mant_i,
   input  logic [OUT_W-1:0]  lz_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [DATA_W-1:0] data_o,
   output logic              sticky_o
);
   localparam int STEP_W = $clog2(OUT_W);
   state_t state, state_nxt;
   logic [STEP_W-1:0] step;
   logic [OUT_W-1:0] lz;
   logic [OUT_W-1:0] amount;
   logic [DATA_W-1:0] work, work_nxt;
   logic sticky, dropped, last;
   assign amount = {{(OUT_W-1){1'b0}}, 1'b1} << step;
   assign last = step == STEP_W'(OUT_W-1);
   lz_denorm_shift_stage #(.DATA_W(DATA_W), .OUT_W(OUT_W)) u_stage (
      .work      (work),
      .amount    (amount),
      .enable    (lz[step]),
      .work_nxt  (work_nxt),
      .dropped_or(dropped)
   );
   always_comb begin
      state_nxt = state;
      state_nxt = state == IDLE  ? (valid_i ? SHIFT : IDLE) :
                  state == SHIFT ? (last ? DONE : SHIFT) :
                                   (ready_i ? IDLE : DONE);
   end
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state  <= IDLE;
         step   <= '0;
         lz     <= '0;
         work   <= '0;
         sticky <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && valid_i) begin
            work   <= DATA_W'(mant_i) << (DATA_W - MANT_W);
            lz     <= lz_i;
            step   <= '0;
            sticky <= 1'b0;
         end else if (state == SHIFT) begin
            work   <= work_nxt;
            sticky <= sticky | dropped;
            step   <= step + 1'b1;
         end
      end
   end
   assign ready_o  = state == IDLE;
   assign valid_o  = state == DONE;
   assign data_o   = work;
   assign sticky_o = sticky;
endmodule

// File: tb/tb_lz_denorm.sv
// tb_lz_denorm: directed and randomized checks of lz_denorm against a bit-position reference model.
module tb_lz_denorm;
   import lz_denorm_pkg::*;
   localparam int DW = DEF_DATA_W;
   localparam int OW = DEF_OUT_W;
   localparam int MW = DEF_MANT_W;
   logic clk_i = 1'b0, rst_n_i = 1'b0, valid_i = 1'b0, ready_i = 1'b0;
   logic ready_o, valid_o, sticky_o;
   logic [MW-1:0] mant_i = '0;
   logic [OW-1:0] lz_i = '0;
   logic [DW-1:0] data_o;
   int checks = 0, failures = 0;
   always #5 clk_i = ~clk_i;
   lz_denorm dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(ready_o),
      .mant_i(mant_i), .lz_i(lz_i), .valid_o(valid_o), .ready_i(ready_i),
      .data_o(data_o), .sticky_o(sticky_o)
   );
   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   // Mantissa bit i lands at i+(DW-MW)-lz; anything landing below 0 is lost into sticky.
   function automatic void model(input logic [MW-1:0] m, input int l, output logic [DW-1:0] d, output logic s);
      d = '0;
      s = 1'b0;
      for (int i = 0; i < MW; i++)
         if (m[i]) begin
            int p;
            p = i + (DW - MW) - l;
            if (p >= 0) d[p] = 1'b1;
            else s = 1'b1;
         end
   endfunction
   function automatic int clz(input logic [DW-1:0] d);
      for (int i = DW - 1; i >= 0; i--)
         if (d[i]) return DW - 1 - i;
      return DW;
   endfunction
   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask
   task automatic start(input logic [MW-1:0] m, input logic [OW-1:0] l);
      int n;
      n = 0;
      while (!ready_o && n < 40) begin
         tick;
         n++;
      end
      check("ready", DW'(ready_o), DW'(1));
      mant_i  = m;
      lz_i    = l;
      valid_i = 1'b1;
      tick;
      valid_i = 1'b0;
   endtask
   task automatic wait_done(output int n);
      n = 0;
      while (!valid_o && n < 40) begin
         tick;
         n++;
      end
   endtask
   task automatic beat(input logic [MW-1:0] m, input int l, input int hold, input bit round);
      logic [DW-1:0] d;
      logic s;
      int n;
      model(m, l, d, s);
      start(m, OW'(l));
      wait_done(n);
      check("latency", DW'(n), DW'(OW));
      check("data", data_o, d);
      check("sticky", DW'(sticky_o), DW'(s));
      if (round) check("clz", DW'(clz(data_o)), DW'(l));
      for (int i = 0; i < hold; i++) begin
         tick;
         check("hold_data", data_o, d);
         check("hold_valid", DW'(valid_o), DW'(1));
      end
      ready_i = 1'b1;
      tick;
      ready_i = 1'b0;
      check("release", DW'(ready_o), DW'(1));
   endtask
   initial begin
      logic [DW-1:0] d;
      logic s;
      int n;
      tick;
      tick;
      check("rst_ready", DW'(ready_o), DW'(1));
      check("rst_valid", DW'(valid_o), DW'(0));
      check("rst_data", data_o, '0);
      check("rst_sticky", DW'(sticky_o), DW'(0));
      rst_n_i = 1'b1;
      tick;
      beat(24'h800000, 0, 0, 1'b1);
      beat(24'hC00001, 255, 0, 1'b1);
      beat(24'hC00001, 256, 0, 1'b1);
      beat(24'h000001, 279, 0, 1'b0);
      beat(24'h000001, 511, 0, 1'b0);
      beat(24'h000000, 5, 0, 1'b0);
      // Backpressure: a valid_i pulse in DONE must be ignored and the result held.
      model(24'hABCDEF, 40, d, s);
      start(24'hABCDEF, 9'd40);
      wait_done(n);
      check("bp_latency", DW'(n), DW'(OW));
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            mant_i  = 24'h123456;
            lz_i    = 9'd7;
            valid_i = 1'b1;
         end
         tick;
         valid_i = 1'b0;
         check("bp_data", data_o, d);
         check("bp_sticky", DW'(sticky_o), DW'(s));
         check("bp_ready", DW'(ready_o), DW'(0));
         check("bp_valid", DW'(valid_o), DW'(1));
      end
      mant_i  = 24'h876543;
      lz_i    = 9'd100;
      valid_i = 1'b1;
      ready_i = 1'b1;
      tick;
      ready_i = 1'b0;
      check("bp_idle_ready", DW'(ready_o), DW'(1));
      check("bp_idle_valid", DW'(valid_o), DW'(0));
      tick;
      valid_i = 1'b0;
      check("bp_accepted", DW'(ready_o), DW'(0));
      wait_done(n);
      model(24'h876543, 100, d, s);
      check("bp2_latency", DW'(n), DW'(OW));
      check("bp2_data", data_o, d);
      check("bp2_sticky", DW'(sticky_o), DW'(s));
      ready_i = 1'b1;
      tick;
      ready_i = 1'b0;
      // Reset in the middle of the shift sequence.
      start(24'h9A0F31, 9'd3);
      repeat (4) tick;
      rst_n_i = 1'b0;
      tick;
      check("mid_rst_valid", DW'(valid_o), DW'(0));
      check("mid_rst_ready", DW'(ready_o), DW'(1));
      check("mid_rst_data", data_o, '0);
      rst_n_i = 1'b1;
      beat(24'hF00000, 100, 1, 1'b1);
      for (int k = 0; k < 1000; k++)
         beat({1'b1, 23'($urandom)}, int'($urandom_range(0, DW - 1)), int'($urandom_range(0, 2)), 1'b1);
      for (int k = 0; k < 200; k++)
         beat(MW'($urandom), int'($urandom_range(0, 511)), 0, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
